// File: rtl/road_sensor_if.sv
// Bundle of the road segment's arrival/light inputs and occupancy/sensor outputs.
// Count width follows CAPACITY so it matches the sensor block it connects to.
interface road_sensor_if #(
    parameter int unsigned CAPACITY = 15
);
    localparam int unsigned CW = $clog2(CAPACITY + 1);

    logic          arrive;
    logic [1:0]    light;
    logic [2:0]    S;
    logic [CW-1:0] count;
    logic          depart;
    logic          reject;

    modport master (
        output arrive,
        output light,
        input  S,
        input  count,
        input  depart,
        input  reject
    );

    modport slave (
        input  arrive,
        input  light,
        output S,
        output count,
        output depart,
        output reject
    );
endinterface

// File: rtl/road_sensor.sv
// Road segment occupancy tracker with timed departures and a thermometer-coded crowding sensor.
// Define ROAD_SENSOR_DEBOUNCE_EN to debounce the sensor output through an IDLE/PEND FSM.
module road_sensor #(
    parameter int unsigned CAPACITY        = 15,
    parameter int unsigned MORE_TH         = 6,
    parameter int unsigned FULL_TH         = 12,
    parameter int unsigned DEPART_INTERVAL = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 3
) (
    input logic          clock,
    input logic          clear,
    road_sensor_if.slave bus
);
    localparam int unsigned CW = $clog2(CAPACITY + 1);
    localparam int unsigned TW = (DEPART_INTERVAL > 1) ? $clog2(DEPART_INTERVAL) : 1;
    localparam logic [CW-1:0] CAP = CW'(CAPACITY);
    localparam logic [TW-1:0] TIMER_LAST = TW'(DEPART_INTERVAL - 1);

    logic [CW-1:0] count_q;
    logic [TW-1:0] timer_q;
    logic          depart_q;
    logic          reject_q;
    logic [2:0]    s_q;
    logic [2:0]    raw;
    logic          active;
    logic          depart_now;

    always_comb begin
        active     = (bus.light == 2'd2) && (count_q != '0);
        depart_now = active && (timer_q == TIMER_LAST);
    end

    always_comb begin
        raw = 3'b000;
        if (count_q == '0) begin
            raw = 3'b000;
        end else if (32'(count_q) < MORE_TH) begin
            raw = 3'b001;
        end else if (32'(count_q) < FULL_TH) begin
            raw = 3'b011;
        end else begin
            raw = 3'b111;
        end
    end

    // A departure frees the slot an arrival on the same edge would take, so count holds.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            count_q  <= '0;
            timer_q  <= '0;
            depart_q <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            depart_q <= depart_now;
            reject_q <= bus.arrive && (count_q == CAP) && !depart_now;
            timer_q  <= (active && !depart_now) ? timer_q + TW'(1) : '0;
            if (bus.arrive && !depart_now && (count_q != CAP)) begin
                count_q <= count_q + CW'(1);
            end else if (!bus.arrive && depart_now) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

`ifdef ROAD_SENSOR_DEBOUNCE_EN
    localparam int unsigned SW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic {IDLE, PEND} state_t;

    state_t        state_q;
    logic [2:0]    cand_q;
    logic [SW-1:0] stab_q;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_q <= IDLE;
            cand_q  <= 3'b000;
            stab_q  <= '0;
            s_q     <= 3'b000;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (raw != s_q) begin
                        if (DEBOUNCE_CYCLES <= 1) begin
                            s_q <= raw;
                        end else begin
                            state_q <= PEND;
                            cand_q  <= raw;
                            stab_q  <= SW'(1);
                        end
                    end
                end
                PEND: begin
                    if (raw == s_q) begin
                        state_q <= IDLE;
                        stab_q  <= '0;
                    end else if (raw == cand_q) begin
                        if (32'(stab_q) + 1 >= DEBOUNCE_CYCLES) begin
                            s_q     <= cand_q;
                            state_q <= IDLE;
                            stab_q  <= '0;
                        end else begin
                            stab_q <= stab_q + SW'(1);
                        end
                    end else begin
                        cand_q <= raw;
                        stab_q <= SW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            s_q <= 3'b000;
        end else begin
            s_q <= raw;
        end
    end
`endif

    assign bus.S      = s_q;
    assign bus.count  = count_q;
    assign bus.depart = depart_q;
    assign bus.reject = reject_q;
endmodule
